// File: rtl/serial_pkg.sv
// Types and clocking constants shared by the serial receive and transmit paths.
// The default bit period assumes a 50 MHz system clock and 9600 baud.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int CLK_HZ               = 50_000_000;
    localparam int BAUD_DEFAULT         = 9600;
    localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD_DEFAULT;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for asynchronous level inputs (serial lines, buttons).
// Each bit is synchronized independently; there is no multi-bit coherency.
module bit_sync #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= RST_VAL;
                    sync_reg[gi] <= RST_VAL;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/serial_rx.sv
// 8N1-style serial receiver: start-bit qualification at half period, data bits
// sampled once per bit period LSB first, one-cycle valid or frame-error strobe.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    rx_state_t             state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc;
    logic [BW-1:0]         bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic [DATA_BITS-1:0]  data_reg, data_next;
    logic                  valid_reg, valid_next;
    logic                  ferr_reg, ferr_next;
    logic                  armed_reg, armed_next;
    logic                  rx_s;

    bit_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign cnt_inc = cnt_reg + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
            armed_reg   <= armed_next;
        end
    end

    // armed only latches while idle, so a line stuck low after a frame error
    // or a break never looks like a fresh start edge.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        armed_next   = armed_reg;

        if (!enable) begin
            state_next   = IDLE;
            cnt_next     = '0;
            bit_idx_next = '0;
            armed_next   = (state_reg == IDLE) ? (armed_reg | rx_s) : 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    if (armed_reg && !rx_s) begin
                        state_next = START;
                        armed_next = 1'b0;
                    end else if (rx_s) begin
                        armed_next = 1'b1;
                    end
                end

                // The start bit is re-checked on the edge where the count
                // reaches HALF-1, i.e. near the middle of the start bit.
                START: begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_HALF) begin
                        cnt_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_idx_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end

                DATA: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next     = '0;
                        shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx_next = bit_idx_reg + BW'(1);
                        if (bit_idx_reg == IDX_LAST) begin
                            state_next = STOP;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end

                STOP: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end

                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (state_reg != IDLE);
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        data_next  = data_reg;
        if (enable && state_reg == STOP && cnt_reg == CNT_LAST) begin
            if (rx_s) begin
                valid_next = 1'b1;
                data_next  = shift_reg;
            end else begin
                ferr_next  = 1'b1;
            end
        end
    end

    assign data_out    = data_reg;
    assign data_valid  = valid_reg;
    assign frame_error = ferr_reg;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at 8 clocks per bit: a table of single frames
// followed by hand-written back-to-back, glitch, break, abort and reset cases.
module tb_serial_rx;

    localparam int CPB   = 8;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * CPB;
    // First driven start-bit cycle to strobe: 2 sync flops + 1 idle edge + 75.
    localparam int LAT   = 78;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_error;
    logic          busy;

    serial_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          v_cyc[$];
    logic [7:0]  v_dat[$];
    int          f_cyc[$];
    bit          busy_hist[4096];
    bit          both_seen = 1'b0;

    always @(negedge clk) begin
        busy_hist[cyc % 4096] = busy;
        if (data_valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(data_out);
        end
        if (frame_error) f_cyc.push_back(cyc);
        if (data_valid && frame_error) both_seen = 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        v_cyc.delete();
        v_dat.delete();
        f_cyc.delete();
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input int abort_at);
        for (int i = 0; i < FRAME; i++) begin
            if (i < CPB)             rx = 1'b0;
            else if (i < (DB+1)*CPB) rx = d[(i - CPB) / CPB];
            else                     rx = stop;
            if (i == abort_at) enable = 1'b0;
            tick(1);
        end
    endtask

    task automatic check_single(input string tag, input int c0, input logic [7:0] exp_d);
        check({tag, " valid count"}, v_cyc.size(), 1);
        check({tag, " error count"}, f_cyc.size(), 0);
        if (v_cyc.size() > 0) begin
            check({tag, " latency"}, v_cyc[0] - c0, LAT);
            check({tag, " data"}, v_dat[0], exp_d);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  c0;
        bit  busy_any;
        string tag;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
        vecs[4] = '{8'h55, 1'b0, 8'h3C, 0, 1};
        vecs[5] = '{8'h01, 1'b1, 8'h01, 1, 0};
        vecs[6] = '{8'h80, 1'b1, 8'h80, 1, 0};

        tick(3);
        check("reset data_out", data_out, 0);
        check("reset data_valid", data_valid, 0);
        check("reset frame_error", frame_error, 0);
        check("reset busy", busy, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(5);

        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("vec%0d", v);
            clear_mon();
            c0 = cyc;
            drive_frame(vecs[v].data, vecs[v].stop, -1);
            rx = 1'b1;
            tick(12);
            check({tag, " valid count"}, v_cyc.size(), vecs[v].exp_valid);
            check({tag, " error count"}, f_cyc.size(), vecs[v].exp_ferr);
            if (v_cyc.size() > 0) begin
                check({tag, " valid latency"}, v_cyc[0] - c0, LAT);
                check({tag, " strobe data"}, v_dat[0], vecs[v].exp_dout);
            end
            if (f_cyc.size() > 0) check({tag, " error latency"}, f_cyc[0] - c0, LAT);
            check({tag, " data_out"}, data_out, vecs[v].exp_dout);
            $display("vec%0d: sent %02h stop=%0d -> data_out=%02h valids=%0d errors=%0d",
                     v, vecs[v].data, vecs[v].stop, data_out, v_cyc.size(), f_cyc.size());
        end

        // Back-to-back frames with no idle gap.
        clear_mon();
        c0 = cyc;
        drive_frame(8'h00, 1'b1, -1);
        drive_frame(8'hFF, 1'b1, -1);
        rx = 1'b1;
        tick(12);
        check("b2b valid count", v_cyc.size(), 2);
        if (v_cyc.size() == 2) begin
            check("b2b first latency", v_cyc[0] - c0, LAT);
            check("b2b spacing", v_cyc[1] - v_cyc[0], FRAME);
            check("b2b first data", v_dat[0], 8'h00);
            check("b2b second data", v_dat[1], 8'hFF);
        end
        $display("b2b: valids=%0d data_out=%02h", v_cyc.size(), data_out);

        // Short low glitch: start qualification must reject it.
        clear_mon();
        c0 = cyc;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(12);
        check("glitch busy in start", busy_hist[(c0 + 5) % 4096], 1);
        check("glitch busy dropped", busy_hist[(c0 + 6) % 4096], 0);
        check("glitch no valid", v_cyc.size(), 0);
        check("glitch no error", f_cyc.size(), 0);
        clear_mon();
        c0 = cyc;
        drive_frame(8'h3C, 1'b1, -1);
        rx = 1'b1;
        tick(12);
        check_single("after glitch", c0, 8'h3C);
        $display("glitch: rejected, following frame data_out=%02h", data_out);

        // Bad stop bit, then line held low: no retrigger until high.
        clear_mon();
        c0 = cyc;
        drive_frame(8'h55, 1'b0, -1);
        tick(40);
        check("break error count", f_cyc.size(), 1);
        if (f_cyc.size() > 0) check("break error latency", f_cyc[0] - c0, LAT);
        check("break no valid", v_cyc.size(), 0);
        check("break data_out kept", data_out, 8'h3C);
        busy_any = 1'b0;
        for (int i = c0 + LAT + 1; i < c0 + FRAME + 40; i++)
            if (busy_hist[i % 4096]) busy_any = 1'b1;
        check("break no restart", busy_any, 0);
        rx = 1'b1;
        tick(12);
        $display("break: errors=%0d data_out=%02h", f_cyc.size(), data_out);

        // Enable dropped during data bit 4.
        clear_mon();
        c0 = cyc;
        drive_frame(8'h81, 1'b1, 44);
        rx = 1'b1;
        tick(12);
        check("abort busy before", busy_hist[(c0 + 44) % 4096], 1);
        check("abort busy after", busy_hist[(c0 + 45) % 4096], 0);
        check("abort no valid", v_cyc.size(), 0);
        check("abort no error", f_cyc.size(), 0);
        check("abort data_out kept", data_out, 8'h3C);
        enable = 1'b1;
        tick(4);
        clear_mon();
        c0 = cyc;
        drive_frame(8'h81, 1'b1, -1);
        rx = 1'b1;
        tick(12);
        check_single("after abort", c0, 8'h81);
        $display("abort: frame discarded, resend data_out=%02h", data_out);

        // Asynchronous reset in the middle of a frame.
        clear_mon();
        for (int i = 0; i < 30; i++) begin
            rx = (i < CPB) ? 1'b0 : ((8'h7E >> ((i - CPB) / CPB)) & 1);
            tick(1);
        end
        check("pre-reset busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check("midreset data_out", data_out, 0);
        check("midreset data_valid", data_valid, 0);
        check("midreset frame_error", frame_error, 0);
        check("midreset busy", busy, 0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        clear_mon();
        c0 = cyc;
        drive_frame(8'h7E, 1'b1, -1);
        rx = 1'b1;
        tick(12);
        check_single("after reset", c0, 8'h7E);
        $display("reset: cleared mid-frame, next frame data_out=%02h", data_out);

        check("valid and error exclusive", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
